// File: rtl/bcd_scan_display.sv
// Time-multiplexed 7-segment driver for cascaded BCD counter digits with
// frame-synchronous capture, leading-zero blanking and a carry/borrow flash LED.
module bcd_scan_display #(
  parameter int DIGITS         = 4,
  parameter int SCAN_DIV       = 50000,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int FLASH_FRAMES   = 8
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic [4*DIGITS-1:0]   bcd,
  input  logic [DIGITS-1:0]     dp,
  input  logic                  blank_lz,
  input  logic                  co,
  output logic [6:0]            seg,
  output logic                  seg_dp,
  output logic [DIGITS-1:0]     an,
  output logic                  co_led,
  output logic                  frame_tick
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int FW = $clog2(FLASH_FRAMES + 1);

  localparam logic [CW-1:0] CNT_LAST   = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_PRE    = CW'(SCAN_DIV - 2);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);
  localparam logic [FW-1:0] FLASH_LOAD = FW'(FLASH_FRAMES);
  localparam logic          INV        = (SEG_ACTIVE_LOW != 0);

  logic [CW-1:0]     cnt;
  logic [IW-1:0]     idx;
  logic [3:0]        shadow_digit [DIGITS];
  logic [DIGITS-1:0] shadow_dp;
  logic              co_prev;
  logic [FW-1:0]     flash;

  logic [DIGITS-1:0] blank_mask;
  logic              zero_run;
  logic [6:0]        seg_hi;
  logic [DIGITS-1:0] an_hi;
  logic              co_rise;

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'h3F;
      4'd1:    decode = 7'h06;
      4'd2:    decode = 7'h5B;
      4'd3:    decode = 7'h4F;
      4'd4:    decode = 7'h66;
      4'd5:    decode = 7'h6D;
      4'd6:    decode = 7'h7D;
      4'd7:    decode = 7'h07;
      4'd8:    decode = 7'h7F;
      4'd9:    decode = 7'h6F;
      default: decode = 7'h40;
    endcase
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (clr) begin
      cnt <= '0;
      idx <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
      idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Registered one cycle early so the pulse lands on the wrap cycle itself.
  always_ff @(posedge clk) begin
    if (clr) frame_tick <= 1'b0;
    else     frame_tick <= (cnt == CNT_PRE) && (idx == IDX_LAST);
  end

  // NOTE: the shadow array is small and must read as a clean 0000 after reset,
  // so it is reset explicitly rather than left as uninitialised storage.
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int k = 0; k < DIGITS; k++) shadow_digit[k] <= 4'd0;
      shadow_dp <= '0;
    end else if (frame_tick) begin
      for (int k = 0; k < DIGITS; k++) shadow_digit[k] <= bcd[4*k +: 4];
      shadow_dp <= dp;
    end
  end

  assign co_rise = co & ~co_prev;

  // co_prev resets high so a counter already carrying at release is not an edge.
  always_ff @(posedge clk) begin
    if (clr) begin
      co_prev <= 1'b1;
      flash   <= '0;
    end else begin
      co_prev <= co;
      if (co_rise)                         flash <= FLASH_LOAD;
      else if (frame_tick && flash != '0)  flash <= flash - 1'b1;
    end
  end

  assign co_led = (flash != '0);

  // NOTE: every combinational output is given a default before the loop, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    zero_run   = blank_lz;
    blank_mask = '0;
    for (int k = DIGITS - 1; k > 0; k--) begin
      zero_run      = zero_run & (shadow_digit[k] == 4'd0);
      blank_mask[k] = zero_run;
    end
    seg_hi = blank_mask[idx] ? 7'h00 : decode(shadow_digit[idx]);
    an_hi  = (cnt == '0) ? '0 : (DIGITS'(1) << idx);
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      seg    <= {7{INV}};
      seg_dp <= INV;
      an     <= {DIGITS{INV}};
    end else begin
      seg    <= seg_hi ^ {7{INV}};
      seg_dp <= shadow_dp[idx] ^ INV;
      an     <= an_hi ^ {DIGITS{INV}};
    end
  end

endmodule

// File: tb/tb_bcd_scan_display.sv
// Directed bench for bcd_scan_display: a per-frame vector table plus hand-written
// sequences for mid-frame capture, CO flash timing and mid-slot reset.
module tb_bcd_scan_display;

  logic        clk;
  logic        clr;
  logic [15:0] bcd;
  logic [3:0]  dp;
  logic        blank_lz;
  logic        co;
  logic [6:0]  seg;
  logic        seg_dp;
  logic [3:0]  an;
  logic        co_led;
  logic        frame_tick;

  int tests;
  int fails;

  bcd_scan_display #(
    .DIGITS(4), .SCAN_DIV(4), .SEG_ACTIVE_LOW(1), .FLASH_FRAMES(2)
  ) dut (
    .clk(clk), .clr(clr), .bcd(bcd), .dp(dp), .blank_lz(blank_lz), .co(co),
    .seg(seg), .seg_dp(seg_dp), .an(an), .co_led(co_led), .frame_tick(frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected active-low segment codes packed {digit3, digit2, digit1, digit0}.
  typedef struct packed {
    logic [15:0] bcd;
    logic [3:0]  dp;
    logic        blz;
    logic [27:0] seg;
    logic [3:0]  sdp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_tick();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_tick && n < 100);
    if (!frame_tick) begin
      tests++;
      fails++;
      $display("FAIL tick_timeout: no frame_tick within 100 cycles");
    end
  endtask

  // Called at the negedge of a frame_tick cycle; outputs at k cycles later
  // reflect scan position s=k-2 of the freshly captured frame.
  task automatic check_frame(input int vi, input vec_t v);
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    int d;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k == 2) begin
        check($sformatf("v%0d_dead_an", vi), an, 4'hF);
        check($sformatf("v%0d_dead_seg", vi), seg, v.seg[6:0]);
      end
      if (k % 4 == 0) begin
        d       = k / 4 - 1;
        exp_an  = ~(4'b0001 << d);
        exp_seg = v.seg[7*d +: 7];
        check($sformatf("v%0d_d%0d_an", vi, d), an, exp_an);
        check($sformatf("v%0d_d%0d_seg", vi, d), seg, exp_seg);
        check($sformatf("v%0d_d%0d_dp", vi, d), seg_dp, v.sdp[d]);
      end
    end
    check($sformatf("v%0d_tick16", vi), frame_tick, 1'b1);
  endtask

  vec_t vecs [6];

  initial begin
    tests = 0;
    fails = 0;
    vecs[0] = '{16'h1234, 4'b0000, 1'b0, {7'h79, 7'h24, 7'h30, 7'h19}, 4'b1111};
    vecs[1] = '{16'h0070, 4'b0000, 1'b1, {7'h7F, 7'h7F, 7'h78, 7'h40}, 4'b1111};
    vecs[2] = '{16'h5678, 4'b0101, 1'b0, {7'h12, 7'h02, 7'h78, 7'h00}, 4'b1010};
    vecs[3] = '{16'h000A, 4'b1000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h3F}, 4'b0111};
    vecs[4] = '{16'h0000, 4'b0000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b1111};
    vecs[5] = '{16'h9FB0, 4'b0000, 1'b1, {7'h10, 7'h3F, 7'h3F, 7'h40}, 4'b1111};

    clr = 1'b1; bcd = 16'h0; dp = 4'h0; blank_lz = 1'b0; co = 1'b0;
    step(2);
    check("rst_seg", seg, 7'h7F);
    check("rst_dp", seg_dp, 1'b1);
    check("rst_an", an, 4'hF);
    check("rst_co_led", co_led, 1'b0);
    check("rst_tick", frame_tick, 1'b0);

    clr = 1'b0;
    step(1);
    check("post_rst_dead_an", an, 4'hF);
    check("post_rst_seg0", seg, 7'h40);
    step(1);
    check("post_rst_an0", an, 4'hE);
    check("post_rst_seg0b", seg, 7'h40);

    for (int i = 0; i < 6; i++) begin
      bcd = vecs[i].bcd; dp = vecs[i].dp; blank_lz = vecs[i].blz;
      wait_tick();
      check_frame(i, vecs[i]);
    end

    // Mid-frame input change must not tear the displayed value.
    bcd = 16'h1234; dp = 4'h0; blank_lz = 1'b0;
    wait_tick();
    step(6);
    bcd = 16'h5678;
    step(2);
    check("tear_d1_an", an, 4'hD);
    check("tear_d1_seg", seg, 7'h30);
    step(8);
    check("tear_d3_seg", seg, 7'h79);
    check("tear_tick", frame_tick, 1'b1);
    step(2);
    check("tear_new_an", an, 4'hF);
    check("tear_new_seg", seg, 7'h00);

    // CO held high: lit next cycle, out after exactly two frame ticks.
    wait_tick();
    step(2);
    co = 1'b1;
    step(1);
    check("co_lit", co_led, 1'b1);
    wait_tick();
    check("co_tick1", co_led, 1'b1);
    step(1);
    check("co_after_tick1", co_led, 1'b1);
    wait_tick();
    check("co_tick2", co_led, 1'b1);
    step(1);
    check("co_after_tick2", co_led, 1'b0);
    wait_tick();
    step(1);
    check("co_held_no_retrig", co_led, 1'b0);

    // New edge during the flash reloads the count.
    step(2);
    co = 1'b0;
    step(1);
    co = 1'b1;
    step(1);
    check("pulse_lit", co_led, 1'b1);
    wait_tick();
    step(1);
    check("pulse_after_tick1", co_led, 1'b1);
    step(2);
    co = 1'b0;
    step(1);
    co = 1'b1;
    step(1);
    wait_tick();
    step(1);
    check("pulse_reloaded", co_led, 1'b1);
    wait_tick();
    step(1);
    check("pulse_expired", co_led, 1'b0);

    // Mid-slot reset while flashing; co still high at release is not an edge.
    wait_tick();
    step(5);
    co = 1'b0;
    step(1);
    co = 1'b1;
    step(1);
    check("pre_clr_co_led", co_led, 1'b1);
    clr = 1'b1;
    step(1);
    check("clr_an", an, 4'hF);
    check("clr_seg", seg, 7'h7F);
    check("clr_co_led", co_led, 1'b0);
    check("clr_tick", frame_tick, 1'b0);
    clr = 1'b0;
    step(2);
    check("clr_idx_restart", an, 4'hE);
    check("clr_seg_zero", seg, 7'h40);
    check("clr_co_no_edge", co_led, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
